// File: rtl/game_tick_pkg.sv
// Shared types and helpers for the Pong game timebase scheduler.
// Optional hit-driven speed-up is enabled by defining GAME_TICK_SPEEDUP_EN.
package game_tick_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned PERIOD_W = 8;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StPlay  = 2'd2,
    StPause = 2'd3
  } game_state_e;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One strobe channel: counts base ticks and emits a registered one-cycle strobe
// every `period` base ticks while run is high.
module tick_channel
  import game_tick_pkg::*;
(
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                clear,
  input  logic                run,
  input  logic                base_tick,
  input  logic [PERIOD_W-1:0] period,
  output logic                strobe
);

  logic [PERIOD_W-1:0] cnt_q;

  // >= rather than == so a period shrinking under the count fires on the next tick.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_q  <= '0;
      strobe <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      strobe <= 1'b0;
    end else if (run && base_tick) begin
      if (cnt_q >= period - PERIOD_W'(1)) begin
        cnt_q  <= '0;
        strobe <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + PERIOD_W'(1);
        strobe <= 1'b0;
      end
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_ctrl.sv
// Pong timebase: shared prescaler, game-phase FSM and ball/paddle strobe channels.
// Define GAME_TICK_SPEEDUP_EN to let paddle hits shorten the ball period.
module game_tick_ctrl
  import game_tick_pkg::*;
#(
  parameter int unsigned BASE_DIV         = 25000,
  parameter int unsigned BALL_PERIOD_INIT = 10,
  parameter int unsigned BALL_PERIOD_MIN  = 3,
  parameter int unsigned PADDLE_PERIOD    = 5,
  parameter int unsigned SERVE_TICKS      = 1000,
  parameter int unsigned HITS_PER_SPEEDUP = 4
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_START,
  input  logic                i_PAUSE,
  input  logic                i_HIT,
  input  logic                i_SCORE,
  output logic                o_BALL_TICK,
  output logic                o_PADDLE_TICK,
  output logic [STATE_W-1:0]  o_STATE,
  output logic [PERIOD_W-1:0] o_BALL_PERIOD
);

  localparam int unsigned PRESC_W = presc_width(BASE_DIV);
  localparam int unsigned SERVE_W = presc_width(SERVE_TICKS);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(BASE_DIV - 1);
  localparam logic [SERVE_W-1:0]  SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [PERIOD_W-1:0] BALL_INIT  = PERIOD_W'(BALL_PERIOD_INIT);
  localparam logic [PERIOD_W-1:0] PADDLE_P   = PERIOD_W'(PADDLE_PERIOD);

  game_state_e         state_q, ret_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [SERVE_W-1:0]  serve_q;
  logic                running, ball_run, base_tick;
  logic                score_act, pause_act, start_act, go_serve, serve_done, chan_clear;
  logic [PERIOD_W-1:0] ball_period;

  assign running    = (state_q == StServe) || (state_q == StPlay);
  assign ball_run   = (state_q == StPlay);
  assign base_tick  = running && (presc_q == PRESC_LAST);
  assign score_act  = i_SCORE && (state_q != StIdle);
  assign pause_act  = i_PAUSE && !i_SCORE && (state_q != StIdle);
  assign start_act  = i_START && !i_SCORE && !i_PAUSE && (state_q == StIdle);
  assign go_serve   = score_act || start_act;
  assign serve_done = (state_q == StServe) && base_tick && (serve_q == SERVE_LAST);
  assign chan_clear = (state_q == StIdle) || go_serve;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= StIdle;
      ret_q   <= StServe;
      presc_q <= '0;
      serve_q <= '0;
    end else begin
      // Prescaler holds in PAUSE so the interrupted interval resumes intact.
      if (state_q == StIdle || base_tick) begin
        presc_q <= '0;
      end else if (running) begin
        presc_q <= presc_q + PRESC_W'(1);
      end

      if (base_tick && (state_q == StServe) && !serve_done) begin
        serve_q <= serve_q + SERVE_W'(1);
      end

      if (go_serve) begin
        state_q <= StServe;
        presc_q <= '0;
        serve_q <= '0;
      end else if (pause_act) begin
        if (state_q == StPause) begin
          state_q <= ret_q;
        end else begin
          // A pause landing on the final serve tick must still resume into PLAY.
          ret_q   <= serve_done ? StPlay : state_q;
          state_q <= StPause;
        end
      end else if (serve_done) begin
        state_q <= StPlay;
      end
    end
  end

`ifdef GAME_TICK_SPEEDUP_EN
  localparam int unsigned HIT_W = presc_width(HITS_PER_SPEEDUP);
  localparam logic [HIT_W-1:0]    HIT_LAST = HIT_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [PERIOD_W-1:0] BALL_MIN = PERIOD_W'(BALL_PERIOD_MIN);

  logic [HIT_W-1:0]    hit_q;
  logic [PERIOD_W-1:0] period_q;
  logic                hit_act;

  assign hit_act = i_HIT && !i_SCORE && !i_PAUSE && !i_START && (state_q == StPlay);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      hit_q    <= '0;
      period_q <= BALL_INIT;
    end else if (score_act) begin
      hit_q    <= '0;
      period_q <= BALL_INIT;
    end else if (hit_act) begin
      if (hit_q == HIT_LAST) begin
        hit_q    <= '0;
        period_q <= (period_q > BALL_MIN) ? period_q - PERIOD_W'(1) : BALL_MIN;
      end else begin
        hit_q <= hit_q + HIT_W'(1);
      end
    end
  end

  assign ball_period = period_q;
`else
  localparam int unsigned unused_cfg = BALL_PERIOD_MIN + HITS_PER_SPEEDUP;
  logic unused_hit;
  assign unused_hit  = i_HIT;
  assign ball_period = BALL_INIT;
`endif

  tick_channel u_ball (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .clear     (chan_clear),
    .run       (ball_run),
    .base_tick (base_tick),
    .period    (ball_period),
    .strobe    (o_BALL_TICK)
  );

  tick_channel u_paddle (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .clear     (chan_clear),
    .run       (running),
    .base_tick (base_tick),
    .period    (PADDLE_P),
    .strobe    (o_PADDLE_TICK)
  );

  assign o_STATE       = state_q;
  assign o_BALL_PERIOD = ball_period;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with small parameters; covers both builds
// of GAME_TICK_SPEEDUP_EN.
module tb_game_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, hit = 1'b0, score = 1'b0;
  logic       ball_tick, paddle_tick;
  logic [1:0] state;
  logic [7:0] ball_period;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ball = 0, ball_gap = 0, ball_cnt = 0;
  int last_pad  = 0, pad_gap  = 0, pad_cnt  = 0;

  game_tick_ctrl #(
    .BASE_DIV         (4),
    .BALL_PERIOD_INIT (3),
    .BALL_PERIOD_MIN  (1),
    .PADDLE_PERIOD    (2),
    .SERVE_TICKS      (5),
    .HITS_PER_SPEEDUP (2)
  ) dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_START       (start),
    .i_PAUSE       (pause),
    .i_HIT         (hit),
    .i_SCORE       (score),
    .o_BALL_TICK   (ball_tick),
    .o_PADDLE_TICK (paddle_tick),
    .o_STATE       (state),
    .o_BALL_PERIOD (ball_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and log strobes.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ball_tick === 1'b1) begin
      ball_gap  = cyc - last_ball;
      last_ball = cyc;
      ball_cnt++;
    end
    if (paddle_tick === 1'b1) begin
      pad_gap  = cyc - last_pad;
      last_pad = cyc;
      pad_cnt++;
    end
  endtask

  task automatic next_ball(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ball_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic next_pad(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (paddle_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at, lb, snap, entry, exp_period;

    // Reset values while reset is held.
    #12;
    check("rst_state", int'(state), 0);
    check("rst_ball_tick", int'(ball_tick), 0);
    check("rst_pad_tick", int'(paddle_tick), 0);
    check("rst_period", int'(ball_period), 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    check("idle_state", int'(state), 0);

    // Start: serve entry is cycle 0.
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; last_ball = 0; last_pad = 0; ball_cnt = 0; pad_cnt = 0;
    check("serve_state", int'(state), 1);
    repeat (19) step();
    check("serve_state_c19", int'(state), 1);
    step();
    check("play_state_c20", int'(state), 2);
    check("serve_pad_cnt", pad_cnt, 2);
    check("serve_pad_gap", pad_gap, 8);
    check("serve_ball_cnt", ball_cnt, 0);
    next_ball(at);
    check("first_ball", at, 32);
    next_ball(at);
    check("second_ball", at, 44);

`ifdef GAME_TICK_SPEEDUP_EN
    hit = 1'b1;
    step();
    step();
    hit = 1'b0;
    check("period_after_2hits", int'(ball_period), 2);
    next_ball(at);
    check("ball_p2_first", at, 52);
    next_ball(at);
    check("ball_p2_gap", ball_gap, 8);
    hit = 1'b1;
    step();
    step();
    hit = 1'b0;
    check("period_after_4hits", int'(ball_period), 1);
    hit = 1'b1;
    step();
    step();
    hit = 1'b0;
    check("period_clamped", int'(ball_period), 1);
    check("ball_p1_at", last_ball, 64);
    check("ball_p1_gap", ball_gap, 4);
    exp_period = 1;
`else
    for (int i = 0; i < 10; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
    end
    check("period_const", int'(ball_period), 3);
    next_ball(at);
    check("ball_off_at", at, 68);
    check("ball_off_gap", ball_gap, 12);
    exp_period = 3;
`endif

    // Pause one cycle after a ball strobe, hold 50 cycles, resume.
    lb = last_ball;
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("pause_state", int'(state), 3);
    snap = ball_cnt + pad_cnt;
    repeat (50) step();
    check("pause_no_strobes", ball_cnt + pad_cnt - snap, 0);
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("resume_state", int'(state), 2);
    next_ball(at);
    check("resume_ball_at", at, lb + 4 * exp_period + 51);

    // Score and pause together: score wins.
    score = 1'b1;
    pause = 1'b1;
    step();
    score = 1'b0;
    pause = 1'b0;
    entry = cyc;
    check("score_state", int'(state), 1);
    check("score_period", int'(ball_period), 3);
    next_pad(at);
    check("score_pad_restart", at - entry, 8);
    repeat (12) step();
    check("replay_state", int'(state), 2);
    repeat (4) step();
    check("pad_before_rst", int'(paddle_tick), 1);

    // Asynchronous reset between edges while a strobe is high.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pad", int'(paddle_tick), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_period", int'(ball_period), 3);
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_pad", int'(paddle_tick), 0);
    check("post_rst_ball", int'(ball_tick), 0);
    check("post_rst_state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
